// File: rtl/demux_1to8_seq.sv
// demux_1to8_seq: registered 1-to-8 serial demultiplexer.
// Auto mode walks the lanes 0..7 with an internal pointer (IDLE/FILL/DONE),
// manual mode writes the lane picked by S. Optional feature macro:
// DEMUX_PARITY_EN adds a PARITY state after lane 7 and the parity_err output.
// Handshake: D is consumed on a rising edge only while D_valid is high; there
// is no back-pressure, every valid bit is accepted on the edge it is presented.
module demux_1to8_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       D,
  input  logic       D_valid,
  input  logic       mode,
  input  logic [2:0] S,
  input  logic       clear,
  output logic [7:0] Y,
  output logic [7:0] Y_strobe,
  output logic       frame_done,
  output logic [2:0] lane_ptr,
`ifdef DEMUX_PARITY_EN
  output logic       parity_err,
`endif
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
`ifdef DEMUX_PARITY_EN
    ST_PARITY = 2'd3,
`endif
    ST_DONE   = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_y;
  logic [7:0] r_strobe;
  logic       r_mode_q;

  state_t     w_state_cur;
  state_t     w_state_nxt;
  logic       w_abort;
  logic [2:0] w_ptr_cur;
  logic [2:0] w_ptr_nxt;
  logic [7:0] w_y_nxt;
  logic [7:0] w_strobe_nxt;

`ifdef DEMUX_PARITY_EN
  logic       r_perr;
  logic       w_perr_nxt;
`endif

  // A mode flip since the last edge drops any partial frame before this
  // edge's bit is handled, so the bit is processed from a fresh IDLE.
  assign w_abort     = (mode != r_mode_q);
  assign w_state_cur = w_abort ? ST_IDLE : r_state;
  assign w_ptr_cur   = w_abort ? 3'd0 : r_ptr;

  // State and datapath registers; reset discards everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 3'd0;
      r_y      <= 8'h00;
      r_strobe <= 8'h00;
      r_mode_q <= 1'b0;
`ifdef DEMUX_PARITY_EN
      r_perr   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_y      <= w_y_nxt;
      r_strobe <= w_strobe_nxt;
      r_mode_q <= mode;
`ifdef DEMUX_PARITY_EN
      r_perr   <= w_perr_nxt;
`endif
    end
  end

  // Next state, lane pointer, lane data and strobe; clear wins over D_valid.
  always_comb begin
    w_state_nxt  = w_state_cur;
    w_ptr_nxt    = w_ptr_cur;
    w_y_nxt      = r_y;
    w_strobe_nxt = 8'h00;
`ifdef DEMUX_PARITY_EN
    w_perr_nxt   = 1'b0;
`endif
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_ptr_nxt   = 3'd0;
      w_y_nxt     = 8'h00;
    end else if (mode) begin
      // Manual mode never runs a frame; the pointer is left alone.
      w_state_nxt = ST_IDLE;
      if (D_valid) begin
        w_y_nxt[S]      = D;
        w_strobe_nxt[S] = 1'b1;
      end
    end else begin
      case (w_state_cur)
        // DONE behaves like IDLE so a bit in the DONE cycle starts the next frame.
        ST_IDLE, ST_DONE: begin
          if (D_valid) begin
            w_y_nxt[0]      = D;
            w_strobe_nxt[0] = 1'b1;
            w_ptr_nxt       = 3'd1;
            w_state_nxt     = ST_FILL;
          end else begin
            w_ptr_nxt   = 3'd0;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_FILL: begin
          if (D_valid) begin
            w_y_nxt[w_ptr_cur]      = D;
            w_strobe_nxt[w_ptr_cur] = 1'b1;
            if (w_ptr_cur == 3'd7) begin
              w_ptr_nxt   = 3'd0;
`ifdef DEMUX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_DONE;
`endif
            end else begin
              w_ptr_nxt = w_ptr_cur + 3'd1;
            end
          end
        end
`ifdef DEMUX_PARITY_EN
        // The parity bit is checked against the completed frame, never stored.
        ST_PARITY: begin
          if (D_valid) begin
            w_perr_nxt  = (^r_y) ^ D;
            w_state_nxt = ST_DONE;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Outputs come straight from registers; frame_done is the DONE state itself.
  always_comb begin
    Y          = r_y;
    Y_strobe   = r_strobe;
    lane_ptr   = r_ptr;
    frame_done = (r_state == ST_DONE);
    state_dbg  = r_state;
`ifdef DEMUX_PARITY_EN
    parity_err = r_perr & (r_state == ST_DONE);
`endif
  end

endmodule

// File: tb/tb_demux_1to8_seq.sv
// Directed-vector bench for demux_1to8_seq with an expected-value queue.
module tb_demux_1to8_seq;

  localparam int W = 21;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       d = 1'b0;
  logic       d_valid = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] s = 3'd0;
  logic       clear = 1'b0;
  logic [7:0] y;
  logic [7:0] y_strobe;
  logic       frame_done;
  logic [2:0] lane_ptr;
  logic [1:0] state_dbg;
  logic       perr_w;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] cur_y;

  demux_1to8_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .D          (d),
    .D_valid    (d_valid),
    .mode       (mode),
    .S          (s),
    .clear      (clear),
    .Y          (y),
    .Y_strobe   (y_strobe),
    .frame_done (frame_done),
    .lane_ptr   (lane_ptr),
`ifdef DEMUX_PARITY_EN
    .parity_err (perr_w),
`endif
    .state_dbg  (state_dbg)
  );

`ifndef DEMUX_PARITY_EN
  assign perr_w = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] lo_mask(input int i);
    return 8'((1 << (i + 1)) - 1);
  endfunction

  // driver: present one edge of stimulus and queue the expected outputs
  task automatic step(input logic a_d, input logic a_dv, input logic a_md,
                      input logic [2:0] a_s, input logic a_clr,
                      input logic [7:0] ey, input logic [7:0] es,
                      input logic efd, input logic [2:0] eptr, input logic eperr);
    @(negedge clk);
    d = a_d; d_valid = a_dv; mode = a_md; s = a_s; clear = a_clr;
    @(posedge clk);
    exp_q.push_back({ey, es, efd, eptr, eperr});
  endtask

  // direct check while reset is held low (no clock edge involved)
  task automatic chk_rst(input string tag);
    n_vec++;
    if (y !== 8'h00 || y_strobe !== 8'h00 || frame_done !== 1'b0 ||
        lane_ptr !== 3'd0 || perr_w !== 1'b0 || state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL %s: Y=%h strobe=%h fd=%b ptr=%0d perr=%b st=%0d, required all zero",
               tag, y, y_strobe, frame_done, lane_ptr, perr_w, state_dbg);
    end
  endtask

  // scoreboard monitor: one expected entry per stimulus edge, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] g;
      e = exp_q.pop_front();
      g = {y, y_strobe, frame_done, lane_ptr, perr_w};
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL vec%0d: Y=%h/%h strobe=%h/%h fd=%b/%b ptr=%0d/%0d perr=%b/%b (got/required)",
                 n_vec, g[20:13], e[20:13], g[12:5], e[12:5], g[4], e[4],
                 g[3:1], e[3:1], g[0], e[0]);
      end
    end
  end

  initial begin
    logic [7:0] fa;
    logic [7:0] fb;
    // power-on reset, checked asynchronously
    #1 rst_n = 1'b0;
    #1 chk_rst("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // idle, no strobe after release
    step(0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 0, 3'd0, 0);

    // auto frame 8'b01001101, LSB first; frame_done after the 8th bit
    fa = 8'b01001101;
    for (int i = 0; i < 8; i++)
      step(fa[i], 1, 0, 3'd0, 0, fa & lo_mask(i), 8'(1 << i), (i == 7), 3'((i + 1) % 8), 0);
    step(0, 0, 0, 3'd0, 0, fa, 8'h00, 0, 3'd0, 0);

    // manual mode
    step(0, 1, 0, 3'd0, 1, 8'h00, 8'h00, 0, 3'd0, 0);
    step(1, 1, 1, 3'd5, 0, 8'h20, 8'h20, 0, 3'd0, 0);
    step(1, 1, 1, 3'd2, 0, 8'h24, 8'h04, 0, 3'd0, 0);
    step(0, 1, 1, 3'd5, 0, 8'h04, 8'h20, 0, 3'd0, 0);
    step(1, 0, 1, 3'd6, 0, 8'h04, 8'h00, 0, 3'd0, 0);

    // clear priority after 3 auto bits
    step(0, 0, 0, 3'd0, 1, 8'h00, 8'h00, 0, 3'd0, 0);
    step(1, 1, 0, 3'd0, 0, 8'h01, 8'h01, 0, 3'd1, 0);
    step(1, 1, 0, 3'd0, 0, 8'h03, 8'h02, 0, 3'd2, 0);
    step(1, 1, 0, 3'd0, 0, 8'h07, 8'h04, 0, 3'd3, 0);
    step(1, 1, 0, 3'd0, 1, 8'h00, 8'h00, 0, 3'd0, 0);
    step(1, 1, 0, 3'd0, 0, 8'h01, 8'h01, 0, 3'd1, 0);

    // mode-change abort mid-frame, bit on the switching edge uses new mode
    step(0, 1, 0, 3'd0, 0, 8'h01, 8'h02, 0, 3'd2, 0);
    step(1, 1, 1, 3'd7, 0, 8'h81, 8'h80, 0, 3'd0, 0);
    step(0, 1, 0, 3'd0, 0, 8'h80, 8'h01, 0, 3'd1, 0);
    step(1, 0, 0, 3'd0, 0, 8'h80, 8'h00, 0, 3'd1, 0);

    // back-to-back frames A5 then 3C
    step(0, 0, 0, 3'd0, 1, 8'h00, 8'h00, 0, 3'd0, 0);
    fa = 8'hA5;
    fb = 8'h3C;
    for (int i = 0; i < 8; i++)
      step(fa[i], 1, 0, 3'd0, 0, fa & lo_mask(i), 8'(1 << i), (i == 7), 3'((i + 1) % 8), 0);
    for (int j = 0; j < 8; j++)
      step(fb[j], 1, 0, 3'd0, 0, (fb & lo_mask(j)) | (fa & ~lo_mask(j)), 8'(1 << j),
           (j == 7), 3'((j + 1) % 8), 0);
    step(0, 0, 0, 3'd0, 0, fb, 8'h00, 0, 3'd0, 0);

    // reset mid-frame after 5 bits
    fa = 8'h15;
    for (int i = 0; i < 5; i++)
      step(fa[i], 1, 0, 3'd0, 0, (fa & lo_mask(i)) | (fb & ~lo_mask(i)), 8'(1 << i), 0, 3'(i + 1), 0);
    @(negedge clk);
    d_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_rst("async_rst");
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 0, 3'd0, 0);
    step(1, 1, 0, 3'd0, 0, 8'h01, 8'h01, 0, 3'd1, 0);

`ifdef DEMUX_PARITY_EN
    // parity frames: A5 has even ones, so parity bit 0 is good and 1 is bad
    step(0, 0, 0, 3'd0, 1, 8'h00, 8'h00, 0, 3'd0, 0);
    fa = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      cur_y = (k == 0) ? 8'h00 : fa;
      for (int i = 0; i < 8; i++)
        step(fa[i], 1, 0, 3'd0, 0, (fa & lo_mask(i)) | (cur_y & ~lo_mask(i)), 8'(1 << i),
             0, 3'((i + 1) % 8), 0);
      step(1'(k), 1, 0, 3'd0, 0, fa, 8'h00, 1, 3'd0, 1'(k));
      step(0, 0, 0, 3'd0, 0, fa, 8'h00, 0, 3'd0, 0);
    end
`endif

    // drain the scoreboard with a bounded wait
    @(negedge clk);
    d_valid = 1'b0;
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
